// File: rtl/fixed_point_muldiv.sv
// Shared signed fixed-point multiply/divide engine with valid/ready channels.
// Build option: define FIXED_POINT_SATURATE_EN to clamp overflowing results instead of wrapping.
module fixed_point_muldiv #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(QW - 1);
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef FIXED_POINT_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

    // Magnitude of a two's complement value; |MIN| fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + ONE_V) : x;
    endfunction

    // Out-of-range values either clamp toward their sign or keep the low bits.
    function automatic logic [WIDTH-1:0] range_fix(input logic ovf, input logic neg,
                                                   input logic [WIDTH-1:0] wrapped);
        if (SAT_EN && ovf) return neg ? MIN_V : MAX_V;
        else               return wrapped;
    endfunction

    state_t               state_r, state_n;
    logic [WIDTH-1:0]     a_r, b_r;
    logic                 neg_r;
    logic [QW-1:0]        quo_r;
    logic [WIDTH:0]       rem_r, dvs_r;
    logic [CW-1:0]        cnt_r;
    logic                 in_ready_r, out_valid_r, overflow_r, dbz_r;
    logic [WIDTH-1:0]     result_r;

    logic                 accept_s;
    logic [2*WIDTH-1:0]   prod_s, prod_sh_s;
    logic                 mul_ovf_s;
    logic [WIDTH:0]       trial_s;
    logic                 ge_s;
    logic                 fix_ovf_s;
    logic [WIDTH-1:0]     fix_wrap_s;

    assign accept_s  = in_valid & in_ready_r;
    assign prod_s    = {{WIDTH{a_r[WIDTH-1]}}, a_r} * {{WIDTH{b_r[WIDTH-1]}}, b_r};
    assign prod_sh_s = $signed(prod_s) >>> FRAC;
    assign mul_ovf_s = ~((&prod_sh_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_sh_s[2*WIDTH-1:WIDTH-1]));
    // Restoring step: shift the next dividend bit into the partial remainder.
    assign trial_s   = (rem_r << 1) | {{WIDTH{1'b0}}, quo_r[QW-1]};
    assign ge_s      = (trial_s >= dvs_r);
    // A negative result may reach |MIN|; a positive one must stay at or below MAX.
    assign fix_ovf_s = neg_r ? ((|quo_r[QW-1:WIDTH]) | (quo_r[WIDTH-1] & (|quo_r[WIDTH-2:0])))
                             : (|quo_r[QW-1:WIDTH-1]);
    assign fix_wrap_s = neg_r ? (~quo_r[WIDTH-1:0] + ONE_V) : quo_r[WIDTH-1:0];

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign overflow    = overflow_r;
    assign div_by_zero = dbz_r;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!op)                          state_n = ST_MUL;
                    else if (b == {WIDTH{1'b0}})      state_n = ST_DONE;
                    else                              state_n = ST_DIV;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MUL:  state_n = ST_DONE;
            ST_DIV: begin
                if (cnt_r == CNT_LAST) state_n = ST_FIX;
                else                   state_n = ST_DIV;
            end
            ST_FIX:  state_n = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
                else           state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand latch and divider datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            neg_r <= 1'b0;
            quo_r <= {QW{1'b0}};
            rem_r <= {(WIDTH+1){1'b0}};
            dvs_r <= {(WIDTH+1){1'b0}};
            cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        neg_r <= a[WIDTH-1] ^ b[WIDTH-1];
                        quo_r <= {abs_w(a), {FRAC{1'b0}}};
                        rem_r <= {(WIDTH+1){1'b0}};
                        dvs_r <= {1'b0, abs_w(b)};
                        cnt_r <= {CW{1'b0}};
                    end
                end
                ST_DIV: begin
                    rem_r <= ge_s ? (trial_s - dvs_r) : trial_s;
                    quo_r <= {quo_r[QW-2:0], ge_s};
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake, result and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        overflow_r <= 1'b0;
                        dbz_r      <= 1'b0;
                        if (op && (b == {WIDTH{1'b0}})) begin
                            dbz_r    <= 1'b1;
                            result_r <= a[WIDTH-1] ? MIN_V : MAX_V;
                        end
                    end
                end
                ST_MUL: begin
                    result_r   <= range_fix(mul_ovf_s, prod_sh_s[2*WIDTH-1], prod_sh_s[WIDTH-1:0]);
                    overflow_r <= mul_ovf_s;
                end
                ST_FIX: begin
                    result_r   <= range_fix(fix_ovf_s, neg_r, fix_wrap_s);
                    overflow_r <= fix_ovf_s;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_muldiv.sv
// Self-checking bench for fixed_point_muldiv at the default Q12.20 format.
module tb_fixed_point_muldiv;
`ifdef FIXED_POINT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    fixed_point_muldiv #(.WIDTH(32), .FRAC(20)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          ovf;
        bit          dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact arithmetic on 64-bit integers, then range handling.
    function automatic void model(input bit op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                  output logic [31:0] r, output bit ovf, output bit dbz);
        longint sa, sb, q;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        dbz = 1'b0;
        ovf = 1'b0;
        if (op_i && sb == 64'sd0) begin
            dbz = 1'b1;
            r = (sa >= 64'sd0) ? MAXV : MINV;
        end else begin
            if (!op_i) q = (sa * sb) >>> 20;
            else       q = (sa * 64'sd1048576) / sb;
            ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
            if (ovf && SAT) r = (q < 64'sd0) ? MINV : MAXV;
            else            r = q[31:0];
        end
    endfunction

    // Issue one operation, measure latency, collect the result and release it.
    task automatic run_op(input bit op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output logic [31:0] r_o, output bit ovf_o, output bit dbz_o,
                          output int lat_o);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1; op = op_i; a = a_i; b = b_i;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat_o = 1;
        while (!out_valid && lat_o < 200) begin
            @(posedge clk);
            #1 lat_o++;
        end
        r_o = result; ovf_o = overflow; dbz_o = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);
        chk("out_valid_after_release", {63'd0, out_valid}, 64'd0);
    endtask

    vec_t        tbl[12];
    logic [31:0] r, er, held;
    bit          ov, dz, eov, edz;
    int          lat;

    initial begin
        tbl[0]  = '{1'b0, 32'h0020_0000, 32'h0050_0000, 32'h00A0_0000, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 32'hFFD0_0000, 32'h0008_0000, 32'hFFE8_0000, 1'b0, 1'b0, 2};
        tbl[2]  = '{1'b1, 32'h00A0_0000, 32'h0020_0000, 32'h0050_0000, 1'b0, 1'b0, 54};
        tbl[3]  = '{1'b1, 32'h0010_0000, 32'h0030_0000, 32'h0005_5555, 1'b0, 1'b0, 54};
        tbl[4]  = '{1'b1, 32'hFFF0_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 32'h0010_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b0, 32'h7FF0_0000, 32'h0020_0000, SAT ? 32'h7FFF_FFFF : 32'hFFE0_0000, 1'b1, 1'b0, 2};
        tbl[7]  = '{1'b1, 32'h8000_0000, 32'hFFF0_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b1, 1'b0, 54};
        tbl[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b1, 32'hFFE8_0000, 32'h0020_0000, 32'hFFF4_0000, 1'b0, 1'b0, 54};
        tbl[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0008_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 2};
        tbl[11] = '{1'b1, 32'hFFF0_0000, 32'h0030_0000, 32'hFFFA_AAAB, 1'b0, 1'b0, 54};

        #12;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_flags", {62'd0, overflow, div_by_zero}, 64'd0);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, ov, dz, lat);
            chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, tbl[i].res});
            chk($sformatf("vec%0d_overflow", i), {63'd0, ov}, {63'd0, tbl[i].ovf});
            chk($sformatf("vec%0d_div_by_zero", i), {63'd0, dz}, {63'd0, tbl[i].dbz});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        // Backpressure: result held, no accept while the result waits.
        @(negedge clk);
        in_valid = 1'b1; op = 1'b0; a = 32'h0030_0000; b = 32'h0040_0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        held = result;
        chk("bp_result", {32'd0, held}, 64'h0000_0000_00C0_0000);
        in_valid = 1'b1; op = 1'b1; a = 32'h0010_0000; b = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_result_stable", k), {32'd0, result}, 64'h0000_0000_00C0_0000);
            chk($sformatf("bp%0d_flags", k), {62'd0, overflow, div_by_zero}, 64'd0);
            chk($sformatf("bp%0d_in_ready", k), {62'd0, in_ready, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_in_ready_rise", {62'd0, in_ready, out_valid}, 64'd2);

        // Reset in the middle of a divide aborts at once.
        @(negedge clk);
        in_valid = 1'b1; op = 1'b1; a = 32'h00A0_0000; b = 32'h0020_0000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk) reset_n = 1'b1;
        run_op(1'b0, 32'h0020_0000, 32'h0050_0000, r, ov, dz, lat);
        chk("post_abort_mul", {30'd0, ov, dz, r}, 64'h0000_0000_00A0_0000);
        chk("post_abort_latency", 64'(lat), 64'd2);

        // Randomised operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            int ta, tb;
            bit rop;
            ta  = int'($urandom);
            tb  = int'($urandom);
            rop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) ta = ta >>> $urandom_range(4, 24);
            if ($urandom_range(0, 2) != 0) tb = tb >>> $urandom_range(4, 24);
            if ($urandom_range(0, 7) == 0) tb = 0;
            model(rop, ta, tb, er, eov, edz);
            run_op(rop, ta, tb, r, ov, dz, lat);
            chk($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, rop, ta, tb), {32'd0, r}, {32'd0, er});
            chk($sformatf("rnd%0d_flags", i), {62'd0, ov, dz}, {62'd0, eov, edz});
            chk($sformatf("rnd%0d_latency", i), 64'(lat), (!rop) ? 64'd2 : (edz ? 64'd1 : 64'd54));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
